cpu_run_ctrl: RTL and testbench

//  Parametrised run/halt/step controller between the CPU core and its top-level

---
 rtl/cpu_run_ctrl.sv | 170 +++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller between the CPU core and its top-level pins.
// It gates core progress through run_en, holds a PC breakpoint table, and exposes muxed debug counters.
module cpu_run_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int NUM_BP  = 4,
   parameter int STEP_W  = 16,
   parameter int CNT_W   = 32,
   parameter int DEBUG_W = 32,
   localparam int IDX_W  = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   // "continue" is a reserved word in SystemVerilog, so the resume pin is named cont
   input  logic               cont,
   input  logic               halt_req,
   input  logic               step_req,
   input  logic [STEP_W-1:0]  step_count,
   input  logic               bp_we,
   input  logic [IDX_W-1:0]   bp_idx,
   input  logic [ADDR_W-1:0]  bp_addr,
   input  logic               bp_en,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               pc_valid,
   input  logic               instr_retire,
   input  logic               cpu_halt,
   input  logic               cnt_clr,
   input  logic [1:0]         debug_sel,
   output logic               run_en,
   output logic               pwr,
   output logic               halted,
   output logic [2:0]         halt_cause,
   output logic [DEBUG_W-1:0] debug
);
   // state  | meaning
   // RUN    | core free-running
   // STEP   | core runs until step_left retires
   // HALTED | core stopped, waiting for continue or step_req
   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_STEP   = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   localparam logic [2:0] C_NONE = 3'd0;
   localparam logic [2:0] C_EXT  = 3'd1;
   localparam logic [2:0] C_BP   = 3'd2;
   localparam logic [2:0] C_INSN = 3'd3;
   localparam logic [2:0] C_STEP = 3'd4;

   logic [1:0]        state;
   logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
   logic [NUM_BP-1:0] bp_en_q;
   logic [STEP_W-1:0] step_left;
   logic              bp_skip;
   logic              cont_q;
   logic [ADDR_W-1:0] halt_pc;
   logic [CNT_W-1:0]  cycle_cnt;
   logic [CNT_W-1:0]  retire_cnt;
   logic              bp_match;
   logic              bp_hit;
   logic              active;
   logic              cont_rise;

   always_comb begin
      bp_match = 1'b0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (bp_en_q[i] && (bp_addr_q[i] == pc)) bp_match = 1'b1;
      end
   end

   assign bp_hit    = pc_valid & ~bp_skip & bp_match;
   assign active    = (state == S_RUN) | (state == S_STEP);
   assign run_en    = active & ~bp_hit & ~halt_req;
   assign halted    = (state == S_HALTED);
   assign cont_rise = cont & ~cont_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
         bp_en_q <= '0;
      end else if (bp_we) begin
         for (int i = 0; i < NUM_BP; i++) begin
            if (IDX_W'(i) == bp_idx) begin
               bp_addr_q[i] <= bp_addr;
               bp_en_q[i]   <= bp_en;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_RUN;
         halt_cause <= C_NONE;
         halt_pc    <= '0;
         step_left  <= '0;
         bp_skip    <= 1'b0;
         cont_q     <= 1'b0;
         pwr        <= 1'b0;
      end else begin
         pwr    <= 1'b1;
         cont_q <= cont;
         case (state)
            S_RUN, S_STEP: begin
               if (halt_req) begin
                  state      <= S_HALTED;
                  halt_cause <= C_EXT;
                  halt_pc    <= pc;
               end else if (bp_hit) begin
                  state      <= S_HALTED;
                  halt_cause <= C_BP;
                  halt_pc    <= pc;
               end else if (cpu_halt) begin
                  state      <= S_HALTED;
                  halt_cause <= C_INSN;
                  halt_pc    <= pc;
               end else if ((state == S_STEP) && instr_retire) begin
                  if (step_left == STEP_W'(1)) begin
                     state      <= S_HALTED;
                     halt_cause <= C_STEP;
                     halt_pc    <= pc;
                  end
                  step_left <= step_left - STEP_W'(1);
               end
               // the resumed PC is allowed past its own breakpoint exactly once
               if (bp_skip && pc_valid && run_en) bp_skip <= 1'b0;
            end
            S_HALTED: begin
               if (!halt_req) begin
                  if (step_req) begin
                     state      <= S_STEP;
                     halt_cause <= C_NONE;
                     step_left  <= (step_count == '0) ? STEP_W'(1) : step_count;
                     bp_skip    <= 1'b1;
                  end else if (cont_rise) begin
                     state      <= S_RUN;
                     halt_cause <= C_NONE;
                     bp_skip    <= 1'b1;
                  end
               end
            end
            default: state <= S_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else if (cnt_clr) begin
         cycle_cnt  <= '0;
         retire_cnt <= '0;
      end else begin
         if (run_en)       cycle_cnt  <= cycle_cnt + CNT_W'(1);
         if (instr_retire) retire_cnt <= retire_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         debug <= '0;
      end else begin
         case (debug_sel)
            2'd0:    debug <= DEBUG_W'(cycle_cnt);
            2'd1:    debug <= DEBUG_W'(retire_cnt);
            2'd2:    debug <= DEBUG_W'(halt_pc);
            default: debug <= DEBUG_W'({halt_cause, state, pwr});
         endcase
      end
   end
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl.
// Inputs change 1 time unit after the rising edge, and outputs are sampled before the next edge.
module tb_cpu_run_ctrl;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cont, halt_req, step_req;
   logic [15:0] step_count;
   logic        bp_we;
   logic [1:0]  bp_idx;
   logic [31:0] bp_addr;
   logic        bp_en;
   logic [31:0] pc;
   logic        pc_valid, instr_retire, cpu_halt, cnt_clr;
   logic [1:0]  debug_sel;
   logic        run_en, pwr, halted;
   logic [2:0]  halt_cause;
   logic [31:0] debug;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   cpu_run_ctrl dut (
      .clk(clk), .rst_n(rst_n), .cont(cont), .halt_req(halt_req),
      .step_req(step_req), .step_count(step_count), .bp_we(bp_we),
      .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en), .pc(pc),
      .pc_valid(pc_valid), .instr_retire(instr_retire), .cpu_halt(cpu_halt),
      .cnt_clr(cnt_clr), .debug_sel(debug_sel), .run_en(run_en), .pwr(pwr),
      .halted(halted), .halt_cause(halt_cause), .debug(debug)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cont = 0; halt_req = 0; step_req = 0; step_count = 0;
      bp_we = 0; bp_idx = 0; bp_addr = 0; bp_en = 0; pc = 0; pc_valid = 0;
      instr_retire = 0; cpu_halt = 0; cnt_clr = 0; debug_sel = 2'd0;
      #1;
      checks++; if (pwr !== 1'b0) begin errors++; $display("FAIL reset_pwr got %0h exp 0", pwr); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h exp 0", halted); end
      checks++; if (debug !== 32'h0) begin errors++; $display("FAIL reset_debug got %0h exp 0", debug); end
      tick(); tick();
      rst_n = 1'b1;
      tick();
      checks++; if (pwr !== 1'b1) begin errors++; $display("FAIL pwr_up got %0h exp 1", pwr); end
      checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL reset_run_en got %0h exp 1", run_en); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_run_halted got %0h exp 0", halted); end
      for (int i = 0; i < 5; i++) tick();
      checks++; if (debug !== 32'd5) begin errors++; $display("FAIL cycle_cnt_5 got %0h exp 5", debug); end
   endtask

   task automatic test_breakpoint();
      bp_we = 1; bp_idx = 0; bp_addr = 32'h40; bp_en = 1;
      tick();
      bp_we = 0; pc_valid = 1;
      for (int a = 32'h38; a <= 32'h40; a += 4) begin
         pc = a;
         #1;
         checks++;
         if (run_en !== (a != 32'h40)) begin
            errors++; $display("FAIL bp_run_en pc=%0h got %0h exp %0h", a, run_en, (a != 32'h40));
         end
         tick();
         checks++;
         if (halted !== (a == 32'h40)) begin
            errors++; $display("FAIL bp_halted pc=%0h got %0h exp %0h", a, halted, (a == 32'h40));
         end
      end
      checks++; if (halt_cause !== 3'd2) begin errors++; $display("FAIL bp_cause got %0h exp 2", halt_cause); end
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL halted_run_en got %0h exp 0", run_en); end
      debug_sel = 2'd2;
      tick();
      checks++; if (debug !== 32'h40) begin errors++; $display("FAIL halt_pc got %0h exp 40", debug); end
   endtask

   task automatic test_continue();
      cont = 1;
      tick();
      cont = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL cont_resume got %0h exp 0", halted); end
      checks++; if (halt_cause !== 3'd0) begin errors++; $display("FAIL cont_cause got %0h exp 0", halt_cause); end
      checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL bp_skip_fetch got %0h exp 1", run_en); end
      tick();
      pc = 32'h44;
      #1;
      checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL pc44_run_en got %0h exp 1", run_en); end
      tick();
      pc = 32'h40;
      #1;
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL revisit_run_en got %0h exp 0", run_en); end
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL revisit_halted got %0h exp 1", halted); end
      checks++; if (halt_cause !== 3'd2) begin errors++; $display("FAIL revisit_cause got %0h exp 2", halt_cause); end
   endtask

   task automatic test_step();
      bp_we = 1; bp_idx = 0; bp_addr = 32'h40; bp_en = 0;
      tick();
      bp_we = 0; pc_valid = 0;
      step_count = 16'd3; step_req = 1;
      tick();
      step_req = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step_enter got %0h exp 0", halted); end
      for (int k = 0; k < 3; k++) begin
         instr_retire = 1;
         tick();
         instr_retire = 0;
         checks++;
         if (halted !== (k == 2)) begin
            errors++; $display("FAIL step3_retire%0d got %0h exp %0h", k, halted, (k == 2));
         end
         tick();
      end
      checks++; if (halt_cause !== 3'd4) begin errors++; $display("FAIL step3_cause got %0h exp 4", halt_cause); end
      step_count = 16'd0; step_req = 1;
      tick();
      step_req = 0; instr_retire = 1;
      tick();
      instr_retire = 0;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL step0_halted got %0h exp 1", halted); end
      checks++; if (halt_cause !== 3'd4) begin errors++; $display("FAIL step0_cause got %0h exp 4", halt_cause); end
      debug_sel = 2'd1;
      tick();
      checks++; if (debug !== 32'd4) begin errors++; $display("FAIL retire_cnt got %0h exp 4", debug); end
   endtask

   task automatic test_halt_in_step();
      step_count = 16'd4; step_req = 1;
      tick();
      step_req = 0; instr_retire = 1;
      tick(); tick();
      instr_retire = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL step4_running got %0h exp 0", halted); end
      halt_req = 1;
      #1;
      checks++; if (run_en !== 1'b0) begin errors++; $display("FAIL halt_req_run_en got %0h exp 0", run_en); end
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ext_halted got %0h exp 1", halted); end
      checks++; if (halt_cause !== 3'd1) begin errors++; $display("FAIL ext_cause got %0h exp 1", halt_cause); end
      cont = 1;
      tick(); tick();
      halt_req = 0;
      tick();
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL dropped_edge got %0h exp 1", halted); end
      cont = 0;
      tick();
      cont = 1;
      tick();
      cont = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL fresh_edge got %0h exp 0", halted); end
   endtask

   task automatic test_cpu_halt();
      cpu_halt = 1;
      tick();
      cpu_halt = 0;
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL insn_halted got %0h exp 1", halted); end
      checks++; if (halt_cause !== 3'd3) begin errors++; $display("FAIL insn_cause got %0h exp 3", halt_cause); end
      debug_sel = 2'd3;
      tick();
      checks++; if (debug !== 32'h1D) begin errors++; $display("FAIL status got %0h exp 1d", debug); end
      cnt_clr = 1;
      tick();
      cnt_clr = 0; debug_sel = 2'd1;
      tick();
      checks++; if (debug !== 32'd0) begin errors++; $display("FAIL cnt_clr got %0h exp 0", debug); end
   endtask

   task automatic test_reset_mid_step();
      bp_we = 1; bp_idx = 1; bp_addr = 32'h80; bp_en = 1;
      tick();
      bp_we = 0; step_count = 16'd5; step_req = 1; instr_retire = 1;
      tick();
      step_req = 0;
      tick();
      instr_retire = 0;
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL mid_step got %0h exp 0", halted); end
      rst_n = 0;
      #1;
      checks++; if (pwr !== 1'b0) begin errors++; $display("FAIL rst2_pwr got %0h exp 0", pwr); end
      checks++; if (debug !== 32'd0) begin errors++; $display("FAIL rst2_debug got %0h exp 0", debug); end
      tick();
      rst_n = 1; debug_sel = 2'd3;
      tick();
      tick();
      checks++; if (debug !== 32'h1) begin errors++; $display("FAIL rst2_status got %0h exp 1", debug); end
      debug_sel = 2'd1;
      tick();
      checks++; if (debug !== 32'd0) begin errors++; $display("FAIL rst2_retire got %0h exp 0", debug); end
      pc = 32'h80; pc_valid = 1;
      #1;
      checks++; if (run_en !== 1'b1) begin errors++; $display("FAIL bp_cleared got %0h exp 1", run_en); end
      tick();
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL bp_cleared_halt got %0h exp 0", halted); end
   endtask

   initial begin
      test_reset();
      test_breakpoint();
      test_continue();
      test_step();
      test_halt_in_step();
      test_cpu_halt();
      test_reset_mid_step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
